dyadic_boolean_accumulator: RTL

Streaming reduction unit that folds a sequence of input words into one result by repeatedly applying a run-time-selected dyadic Boolean operation between a running accumulator and each incoming word. Any of the 16 two-variable functions is available, for example AND-reduce, OR-reduce, XOR parity, or NOR chains. It sits in ALU and control paths where condition vectors arrive over several cycles and must be combined before a decision, such as multi-word branch predicates and process-control interlocks. Both ports use valid/ready handshakes, and the block accepts one beat per cycle.

---
 rtl/dyadic_boolean_pkg.sv | 42 ++++
 rtl/dyadic_boolean_accumulator_if.sv | 41 ++++
 rtl/Dyadic_Boolean_Operator.sv | 22 ++
 rtl/dyadic_boolean_accumulator.sv | 121 ++++++++++++
 4 files changed

// File: rtl/dyadic_boolean_pkg.sv
// Shared definitions for the dyadic Boolean accumulator slice:
// truth-table widths, named encodings for all 16 two-input functions,
// the controller state enum and the per-bit lookup helper.
// Truth-table index is {a_bit, b_bit}, with the accumulator (a) as MSB.
package dyadic_boolean_pkg;

    localparam int DYADIC_TRUTH_TABLE_WIDTH = 4;
    localparam int DYADIC_SELECTOR_WIDTH    = 2;

    typedef logic [DYADIC_TRUTH_TABLE_WIDTH-1:0] truth_table_t;

    localparam truth_table_t TT_FALSE       = 4'b0000;
    localparam truth_table_t TT_NOR         = 4'b0001;
    localparam truth_table_t TT_NOT_A_AND_B = 4'b0010;
    localparam truth_table_t TT_NOT_A       = 4'b0011;
    localparam truth_table_t TT_A_AND_NOT_B = 4'b0100;
    localparam truth_table_t TT_NOT_B       = 4'b0101;
    localparam truth_table_t TT_XOR         = 4'b0110;
    localparam truth_table_t TT_NAND        = 4'b0111;
    localparam truth_table_t TT_AND         = 4'b1000;
    localparam truth_table_t TT_XNOR        = 4'b1001;
    localparam truth_table_t TT_B           = 4'b1010;
    localparam truth_table_t TT_NOT_A_OR_B  = 4'b1011;
    localparam truth_table_t TT_A           = 4'b1100;
    localparam truth_table_t TT_A_OR_NOT_B  = 4'b1101;
    localparam truth_table_t TT_OR          = 4'b1110;
    localparam truth_table_t TT_TRUE        = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Evaluate one bit of a dyadic function by truth-table lookup.
    function automatic logic dyadic_bit(input truth_table_t tt, input logic a, input logic b);
        logic [DYADIC_SELECTOR_WIDTH-1:0] sel;
        sel = {a, b};
        return tt[sel];
    endfunction

endpackage

// File: rtl/dyadic_boolean_accumulator_if.sv
// Stream interface for dyadic_boolean_accumulator: input beat channel,
// result channel and run-time function select. The output_count signal and
// COUNT_WIDTH parameter exist only when DYADIC_ACCUMULATOR_COUNT_EN is defined.
interface dyadic_boolean_accumulator_if
    import dyadic_boolean_pkg::*;
#(
    parameter int WORD_WIDTH = 8
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
    , parameter int COUNT_WIDTH = 16
`endif
);
    truth_table_t            truth_table;
    logic [WORD_WIDTH-1:0]   init_value;
    logic                    input_valid;
    logic                    input_ready;
    logic [WORD_WIDTH-1:0]   input_data;
    logic                    input_last;
    logic                    output_valid;
    logic                    output_ready;
    logic [WORD_WIDTH-1:0]   output_data;
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
    logic [COUNT_WIDTH-1:0]  output_count;
`endif

    modport master (
        output truth_table, init_value, input_valid, input_data, input_last, output_ready,
        input  input_ready, output_valid, output_data
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
        , input output_count
`endif
    );

    modport slave (
        input  truth_table, init_value, input_valid, input_data, input_last, output_ready,
        output input_ready, output_valid, output_data
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
        , output output_count
`endif
    );

endinterface

// File: rtl/Dyadic_Boolean_Operator.sv
// Bitwise dyadic Boolean operator: every bit of result is the truth-table
// lookup of the matching bits of word_A and word_B. No inter-bit carry.
module Dyadic_Boolean_Operator
    import dyadic_boolean_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] word_A,
    input  logic [WORD_WIDTH-1:0] word_B,
    input  truth_table_t          truth_table,
    output logic [WORD_WIDTH-1:0] result
);

    // Apply the same selected function independently to each bit position.
    always_comb begin
        result = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            result[i] = dyadic_bit(truth_table, word_A[i], word_B[i]);
        end
    end

endmodule

// File: rtl/dyadic_boolean_accumulator.sv
// Streaming reduction unit: folds a valid/ready stream of words into one
// result using a run-time-selected dyadic Boolean function. The function and
// seed are captured on the first beat; later changes are ignored until the
// result has been handed off.
// Optional beat counter: define DYADIC_ACCUMULATOR_COUNT_EN.
module dyadic_boolean_accumulator
    import dyadic_boolean_pkg::*;
#(
    parameter int WORD_WIDTH = 8
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
    , parameter int COUNT_WIDTH = 16
`endif
) (
    input  logic                         clock,
    input  logic                         clear,
    dyadic_boolean_accumulator_if.slave  bus
);

    state_t                 state_r;
    logic [WORD_WIDTH-1:0]  acc_r;
    truth_table_t           tt_r;
    logic                   out_valid_r;
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
    logic [COUNT_WIDTH-1:0] count_r;
`endif

    logic [WORD_WIDTH-1:0]  word_a_s;
    truth_table_t           tt_sel_s;
    logic [WORD_WIDTH-1:0]  next_acc_s;
    logic                   input_ready_s;
    logic                   beat_s;

    // Ready is a pure function of state; held low while clear is asserted.
    assign input_ready_s = (state_r != DONE) & ~clear;
    assign beat_s        = bus.input_valid & input_ready_s;

    // First beat combines with the seed and live function; later beats use the latched ones.
    always_comb begin
        word_a_s = acc_r;
        tt_sel_s = tt_r;
        if (state_r == IDLE) begin
            word_a_s = bus.init_value;
            tt_sel_s = bus.truth_table;
        end else begin
            word_a_s = acc_r;
            tt_sel_s = tt_r;
        end
    end

    Dyadic_Boolean_Operator #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_operator (
        .word_A      (word_a_s),
        .word_B      (bus.input_data),
        .truth_table (tt_sel_s),
        .result      (next_acc_s)
    );

    // Stream controller: accumulate beats, hold the result until it is taken.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            tt_r        <= '0;
            out_valid_r <= 1'b0;
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
            count_r     <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (beat_s) begin
                        tt_r  <= bus.truth_table;
                        acc_r <= next_acc_s;
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
                        count_r <= COUNT_WIDTH'(1);
`endif
                        if (bus.input_last) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_s) begin
                        acc_r <= next_acc_s;
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
                        if (count_r != '1) begin
                            count_r <= count_r + COUNT_WIDTH'(1);
                        end
`endif
                        if (bus.input_last) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.output_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.input_ready  = input_ready_s;
    assign bus.output_valid = out_valid_r;
    assign bus.output_data  = acc_r;
`ifdef DYADIC_ACCUMULATOR_COUNT_EN
    assign bus.output_count = count_r;
`endif

endmodule
